lcd_nibble_tx: RTL

//  Transmitter for the 4-bit HD44780-style character LCD port (lcd_db/lcd_e/lcd_rs/lcd_rw) on the VC707 top level.

---
 rtl/lcd_nibble_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_tx.sv
// rtl/lcd_nibble_tx.sv - 4-bit HD44780-style LCD transmitter with power-on init sequence
module lcd_nibble_tx #(
  parameter int SETUP_CYC      = 4,
  parameter int E_HIGH_CYC     = 24,
  parameter int NIB_GAP_CYC    = 100,
  parameter int CHAR_WAIT_CYC  = 4000,
  parameter int CLEAR_WAIT_CYC = 164000,
  parameter int PWR_WAIT_CYC   = 1500000,
  parameter int INIT_LONG_CYC  = 410000,
  parameter int INIT_SHORT_CYC = 10000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       init_done,
  output logic       busy,
  output logic [3:0] lcd_db,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  // Counter reload values: each wait loads w-1 and runs down to 0, giving exactly w cycles.
  localparam logic [23:0] SETUP_LD = 24'(SETUP_CYC - 1);
  localparam logic [23:0] EHI_LD   = 24'(E_HIGH_CYC - 1);
  localparam logic [23:0] GAP_LD   = 24'(NIB_GAP_CYC - 1);
  localparam logic [23:0] CHAR_LD  = 24'(CHAR_WAIT_CYC - 1);
  localparam logic [23:0] CLEAR_LD = 24'(CLEAR_WAIT_CYC - 1);
  localparam logic [23:0] PWR_LD   = 24'(PWR_WAIT_CYC - 1);
  localparam logic [23:0] LONG_LD  = 24'(INIT_LONG_CYC - 1);
  localparam logic [23:0] SHORT_LD = 24'(INIT_SHORT_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_NIB,
    IDLE,
    SETUP,
    EHI,
    WAIT
  } state_t;

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [1:0]  idx, idx_n;     // init nibble index 0..3
  logic        lo, lo_n;       // 0 = high nibble in flight, 1 = low nibble
  logic [7:0]  data_q, data_n;
  logic [3:0]  db_n;
  logic        e_n, rs_n, done_n;
  logic        is_clear;
  logic [23:0] wait_ld;

  // lcd_rw is hard-wired low: this port never reads the busy flag.
  assign lcd_rw = 1'b0;

  // Clear and return-home commands need the long post-byte wait.
  assign is_clear = !lcd_rs && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  // Select the E-low wait that follows the current strobe.
  always_comb begin
    wait_ld = CHAR_LD;
    if (!init_done) begin
      case (idx)
        2'd0:    wait_ld = LONG_LD;
        2'd1:    wait_ld = SHORT_LD;
        default: wait_ld = CHAR_LD;
      endcase
    end else if (!lo) begin
      wait_ld = GAP_LD;
    end else if (is_clear) begin
      wait_ld = CLEAR_LD;
    end
  end

  // Next-state and next-output logic; everything holds unless a phase ends.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    lo_n    = lo;
    data_n  = data_q;
    db_n    = lcd_db;
    e_n     = lcd_e;
    rs_n    = lcd_rs;
    done_n  = init_done;
    case (state)
      PWR_WAIT: begin
        if (cnt == 24'd0) begin
          state_n = INIT_NIB;
          db_n    = 4'h3;
          rs_n    = 1'b0;
          idx_n   = 2'd0;
          cnt_n   = SETUP_LD;
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end
      INIT_NIB, SETUP: begin
        if (cnt == 24'd0) begin
          state_n = EHI;
          e_n     = 1'b1;
          cnt_n   = EHI_LD;
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end
      EHI: begin
        if (cnt == 24'd0) begin
          state_n = WAIT;
          e_n     = 1'b0;
          cnt_n   = wait_ld;
        end else begin
          cnt_n = cnt - 24'd1;
        end
      end
      WAIT: begin
        if (cnt != 24'd0) begin
          cnt_n = cnt - 24'd1;
        end else if (!init_done) begin
          if (idx == 2'd3) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = INIT_NIB;
            idx_n   = idx + 2'd1;
            db_n    = (idx == 2'd2) ? 4'h2 : 4'h3;
            cnt_n   = SETUP_LD;
          end
        end else if (!lo) begin
          state_n = SETUP;
          lo_n    = 1'b1;
          db_n    = data_q[3:0];
          cnt_n   = SETUP_LD;
        end else begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (in_valid && in_ready) begin
          state_n = SETUP;
          data_n  = in_data;
          rs_n    = in_rs;
          db_n    = in_data[7:4];
          lo_n    = 1'b0;
          cnt_n   = SETUP_LD;
        end
      end
      default: begin
        state_n = PWR_WAIT;
        cnt_n   = PWR_LD;
      end
    endcase
  end

  // State and registered outputs; reset restarts the whole init sequence.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= PWR_WAIT;
      cnt       <= PWR_LD;
      idx       <= 2'd0;
      lo        <= 1'b0;
      data_q    <= 8'h00;
      lcd_db    <= 4'h0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      lo        <= lo_n;
      data_q    <= data_n;
      lcd_db    <= db_n;
      lcd_e     <= e_n;
      lcd_rs    <= rs_n;
      in_ready  <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      init_done <= done_n;
    end
  end

endmodule
